dj_stream_feeder: RTL
=====================

Name: dj_stream_feeder

Overview:
- Avalon-MM write master that drives the dj core's 16-bit slave port from two buffered sample streams (left, right).
- Services the dj core's left/right stream interrupts: each asserted IRQ is answered with a burst of BURST_LEN sample writes to that channel's slave address.
- Sits between the sample source (e.g. SD/SDRAM reader) and the dj core, replacing CPU-driven sample writes.

Parameters:
- BURST_LEN, 16, sample writes issued per serviced interrupt (1..255)
- FIFO_DEPTH, 64, per-channel sample FIFO depth in words; power of two, >= BURST_LEN
- ADDR_LEFT, 1'b0, slave address for left-channel samples
- ADDR_RIGHT, 1'b1, slave address for right-channel samples

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous reset, active low
- left_sample_data  in  16  left input sample
- left_sample_valid  in  1  left input sample valid
- left_sample_ready  out  1  left FIFO can accept; high when not full
- right_sample_data  in  16  right input sample
- right_sample_valid  in  1  right input sample valid
- right_sample_ready  out  1  right FIFO can accept; high when not full
- dj_irq_left  in  1  left stream interrupt from dj core; level, active high
- dj_irq_right  in  1  right stream interrupt from dj core; level, active high
- avm_address  out  1  slave address
- avm_write  out  1  write strobe
- avm_writedata  out  16  sample to slave
- avm_waitrequest  in  1  slave stall
- underrun_left  out  1  one-cycle pulse per left write padded with silence
- underrun_right  out  1  one-cycle pulse per right write padded with silence

Behaviour:
- Reset: already decided — one clock (clk_clk); reset (reset_reset_n) is synchronous and active-low.
  - Reset values: all outputs 0, FIFOs emptied, FSM in IDLE, round-robin pointer = left.
  - Reset mid-burst: avm_write is 0 from the first edge sampling reset low; the burst is abandoned and not resumed.
- FIFO push: on xx_sample_valid & xx_sample_ready.
  - ready = !full, registered. A simultaneous pop does not reopen ready in the same cycle.
- FSM states:
  - IDLE: on any IRQ high, go to SELECT.
  - SELECT (1 cycle): choose channel.
    - Only one IRQ high: take that channel.
    - Both high: take the channel indicated by the round-robin pointer, then toggle the pointer to the other channel.
    - Latch channel and beat counter = BURST_LEN. Go to WRITE.
  - WRITE:
    - avm_write = 1; avm_address = channel's ADDR_x.
    - avm_writedata = FIFO head, or 16'h0000 if that FIFO is empty when the beat is presented.
    - Beat accepted when avm_write & !avm_waitrequest. On acceptance:
      - Pop the FIFO if non-empty; otherwise pulse underrun_x.
      - Decrement the beat counter. At counter 1, go to GAP; else present the next beat next cycle.
  - GAP (1 cycle, write = 0): lets the dj core deassert its IRQ. Go to IDLE.
- Avalon hold rule: while waitrequest = 1, address, write and writedata stay stable.
  - The padding decision (data vs zero) is frozen when the beat is first presented; it does not change while stalled.
- Back-to-back writes are allowed: one accepted beat per cycle when waitrequest = 0.
- IRQ handling:
  - IRQs are level-sensitive and sampled only in IDLE/SELECT. Changes during WRITE are ignored until the burst completes.
  - An IRQ still high after GAP is serviced again.
- Throughput: first write presented 2 cycles after an IRQ rises in IDLE. Burst duration = BURST_LEN + stall cycles.
- Width: beat counter is 8 bits; FIFO count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package dj_pkg:
  - sample width constant (16)
  - FSM state enum {IDLE, SELECT, WRITE, GAP}
  - channel enum {CH_LEFT, CH_RIGHT}
  - slave address constants
- One sub-module, dj_sample_fifo: synchronous single-clock FIFO, parameterised depth.
  - Ports: push/pop/data, full/empty, show-ahead head output.
  - Instantiated twice.

Test Plan:
- Left FIFO preloaded with 16 samples 0x0001..0x0010; pulse dj_irq_left high, waitrequest = 0 -> 16 consecutive writes, address 0, data 0x0001..0x0010; write low for the GAP cycle; no underrun.
- Both IRQs high together, both FIFOs full -> left burst (address 0) first, then right burst (address 1); with both IRQs held high, service alternates L, R, L.
- Right FIFO holds 5 samples, dj_irq_right high -> 5 data writes followed by 11 writes of 0x0000; underrun_right pulses exactly 11 times; FIFO ends empty.
- waitrequest held high for 3 cycles on beat 4 -> address/write/data unchanged for those 3 cycles; exactly 16 accepted beats; no sample dropped or duplicated.
- Push 64 samples into left with no IRQ -> left_sample_ready low after the 64th push; the 65th valid is not accepted.
- reset_reset_n low for 1 cycle at beat 7 of a left burst -> avm_write = 0 next edge; FIFOs empty; after release with IRQ still high, a fresh burst starts at beat 1.

Source files
------------

// File: rtl/dj_pkg.sv
// Shared types and constants for the dj stream feeder and its sample FIFOs.
package dj_pkg;

   localparam int DATA_W = 16;
   localparam int BEAT_W = 8;

   localparam logic ADDR_LEFT_DEF  = 1'b0;
   localparam logic ADDR_RIGHT_DEF = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      WRITE,
      GAP
   } state_t;

   typedef enum logic {
      CH_LEFT,
      CH_RIGHT
   } ch_t;

   function automatic ch_t other_ch(input ch_t ch);
      return (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
   endfunction

endpackage

// File: rtl/dj_sample_fifo.sv
// Single-clock show-ahead sample FIFO; depth must be a power of two (>= 2).
module dj_sample_fifo
   import dj_pkg::*;
#(
   parameter int FIFO_DEPTH = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_empty,
   output logic              o_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] C_ONE   = (AW+1)'(1);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [AW:0]       w_count_nxt;
   logic              r_ready;
   logic              w_push;
   logic              w_pop;

   // Ready is a registered !full, so a push is never accepted into a full FIFO.
   assign w_push  = i_push & r_ready;
   assign w_pop   = i_pop & ~o_empty;
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_ready = r_ready;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_ONE;
         2'b01:   w_count_nxt = r_count - C_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != C_DEPTH);
      end
   end

endmodule

// File: rtl/dj_stream_feeder.sv
// Avalon-MM write master answering dj core stream IRQs with fixed-length
// bursts of left/right samples, padding with silence when a FIFO runs dry.
module dj_stream_feeder
   import dj_pkg::*;
#(
   parameter int   BURST_LEN  = 16,
   parameter int   FIFO_DEPTH = 64,
   parameter logic ADDR_LEFT  = ADDR_LEFT_DEF,
   parameter logic ADDR_RIGHT = ADDR_RIGHT_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [DATA_W-1:0] left_sample_data,
   input  logic              left_sample_valid,
   output logic              left_sample_ready,
   input  logic [DATA_W-1:0] right_sample_data,
   input  logic              right_sample_valid,
   output logic              right_sample_ready,
   input  logic              dj_irq_left,
   input  logic              dj_irq_right,
   output logic              avm_address,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   output logic              underrun_left,
   output logic              underrun_right
);

   localparam logic [BEAT_W-1:0] C_BURST = BEAT_W'(BURST_LEN);
   localparam logic [BEAT_W-1:0] C_LAST  = BEAT_W'(1);

   logic [DATA_W-1:0] w_head_l;
   logic [DATA_W-1:0] w_head_r;
   logic [DATA_W-1:0] w_head_sel;
   logic              w_empty_l;
   logic              w_empty_r;
   logic              w_empty_sel;
   logic              w_pop_l;
   logic              w_pop_r;

   state_t            r_state;
   state_t            w_state_nxt;
   ch_t               r_ch;
   ch_t               w_ch_nxt;
   ch_t               r_rr;
   ch_t               w_rr_nxt;
   logic [BEAT_W-1:0] r_beats;
   logic [BEAT_W-1:0] w_beats_nxt;
   logic              r_held;
   logic              w_held_nxt;
   logic              r_pad;
   logic              w_pad_nxt;

   logic              w_wr;
   logic              w_pad;
   logic              w_accept;
   logic              w_sel_right;

   dj_sample_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo_left (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_push  (left_sample_valid),
      .i_data  (left_sample_data),
      .i_pop   (w_pop_l),
      .o_head  (w_head_l),
      .o_empty (w_empty_l),
      .o_ready (left_sample_ready)
   );

   dj_sample_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo_right (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_push  (right_sample_valid),
      .i_data  (right_sample_data),
      .i_pop   (w_pop_r),
      .o_head  (w_head_r),
      .o_empty (w_empty_r),
      .o_ready (right_sample_ready)
   );

   assign w_sel_right = (r_ch == CH_RIGHT);
   assign w_head_sel  = w_sel_right ? w_head_r : w_head_l;
   assign w_empty_sel = w_sel_right ? w_empty_r : w_empty_l;

   // A beat's pad decision is taken on its first cycle and held through any
   // stall, so a sample landing in an empty FIFO mid-stall cannot alter it.
   assign w_pad    = r_held ? r_pad : w_empty_sel;
   assign w_wr     = (r_state == WRITE);
   assign w_accept = w_wr & ~avm_waitrequest;

   assign avm_write     = w_wr;
   assign avm_address   = w_wr & (w_sel_right ? ADDR_RIGHT : ADDR_LEFT);
   assign avm_writedata = (w_wr & ~w_pad) ? w_head_sel : '0;

   assign w_pop_l        = w_accept & ~w_pad & ~w_sel_right;
   assign w_pop_r        = w_accept & ~w_pad &  w_sel_right;
   assign underrun_left  = w_accept &  w_pad & ~w_sel_right;
   assign underrun_right = w_accept &  w_pad &  w_sel_right;

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_rr_nxt    = r_rr;
      w_beats_nxt = r_beats;
      w_held_nxt  = r_held;
      w_pad_nxt   = r_pad;
      case (r_state)
         IDLE: begin
            if (dj_irq_left | dj_irq_right) begin
               w_state_nxt = SELECT;
            end
         end
         SELECT: begin
            w_beats_nxt = C_BURST;
            w_held_nxt  = 1'b0;
            w_state_nxt = WRITE;
            if (dj_irq_left & dj_irq_right) begin
               w_ch_nxt = r_rr;
               w_rr_nxt = other_ch(r_rr);
            end else if (dj_irq_left) begin
               w_ch_nxt = CH_LEFT;
            end else if (dj_irq_right) begin
               w_ch_nxt = CH_RIGHT;
            end else begin
               // IRQ withdrawn before it could be serviced.
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            if (avm_waitrequest) begin
               w_held_nxt = 1'b1;
               w_pad_nxt  = w_pad;
            end else begin
               w_held_nxt  = 1'b0;
               w_beats_nxt = r_beats - 1'b1;
               if (r_beats == C_LAST) begin
                  w_state_nxt = GAP;
               end
            end
         end
         GAP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
         r_ch    <= CH_LEFT;
         r_rr    <= CH_LEFT;
         r_beats <= '0;
         r_held  <= 1'b0;
         r_pad   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_rr    <= w_rr_nxt;
         r_beats <= w_beats_nxt;
         r_held  <= w_held_nxt;
         r_pad   <= w_pad_nxt;
      end
   end

endmodule
